instr_register_exec: RTL and testbench

INSTR_REGISTER_EXEC -- requirements
Module: instr_register_exec

---
 rtl/instr_register_exec.sv | 171 +++++++++++++++++
 tb/tb_instr_register_exec.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_register_exec.sv
// Instruction register file with a combinational ALU on the write path.
// Each entry stores opcode, operands, signed result and an error flag; reads have 1-cycle latency.
module instr_register_exec #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned OP_WIDTH = 32,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned RW      = 2 * OP_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_en,
  input  logic [AW-1:0]       write_pointer,
  input  logic [3:0]          opcode,
  input  logic [OP_WIDTH-1:0] operand_a,
  input  logic [OP_WIDTH-1:0] operand_b,
  input  logic                clear,
  input  logic                read_en,
  input  logic [AW-1:0]       read_pointer,
  output logic                rd_valid,
  output logic [3:0]          rd_opcode,
  output logic [OP_WIDTH-1:0] rd_op_a,
  output logic [OP_WIDTH-1:0] rd_op_b,
  output logic [RW-1:0]       rd_result,
  output logic                rd_entry_valid,
  output logic                rd_err,
  output logic [AW:0]         entry_count
);

  localparam logic [3:0] OpZero  = 4'd0;
  localparam logic [3:0] OpPassA = 4'd1;
  localparam logic [3:0] OpPassB = 4'd2;
  localparam logic [3:0] OpAdd   = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpMult  = 4'd5;
  localparam logic [3:0] OpDiv   = 4'd6;
  localparam logic [3:0] OpMod   = 4'd7;

  // Entry storage is deliberately left unreset; valid_q alone gates visibility.
  logic [3:0]          op_mem  [DEPTH];
  logic [OP_WIDTH-1:0] a_mem   [DEPTH];
  logic [OP_WIDTH-1:0] b_mem   [DEPTH];
  logic [RW-1:0]       res_mem [DEPTH];
  logic                err_mem [DEPTH];

  logic [DEPTH-1:0] valid_q;
  logic [AW:0]      count_q;

  logic                rd_valid_q;
  logic [3:0]          rd_opcode_q;
  logic [OP_WIDTH-1:0] rd_op_a_q;
  logic [OP_WIDTH-1:0] rd_op_b_q;
  logic [RW-1:0]       rd_result_q;
  logic                rd_entry_valid_q;
  logic                rd_err_q;

  logic wr_in_range;
  logic rd_in_range;
  logic wr_en;
  logic rd_hit;

  // Pointers can only go out of range when DEPTH is not a power of two.
  if (DEPTH == (32'd1 << AW)) begin : g_full_range
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    assign wr_in_range = {1'b0, write_pointer} < (AW + 1)'(DEPTH);
    assign rd_in_range = {1'b0, read_pointer} < (AW + 1)'(DEPTH);
  end

  assign wr_en  = load_en && wr_in_range && !clear;
  assign rd_hit = rd_in_range && valid_q[read_pointer];

  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic signed [RW-1:0] div_b;
  logic signed [RW-1:0] wr_result;
  logic                 wr_err;
  logic                 b_zero;

  always_comb begin
    a_ext     = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    b_ext     = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
    b_zero    = (operand_b == '0);
    // Substitute divisor keeps the divider defined when b is zero; its result is discarded.
    div_b     = b_zero ? RW'(1) : b_ext;
    wr_result = '0;
    wr_err    = 1'b0;
    case (opcode)
      OpZero:  wr_result = '0;
      OpPassA: wr_result = a_ext;
      OpPassB: wr_result = b_ext;
      OpAdd:   wr_result = a_ext + b_ext;
      OpSub:   wr_result = a_ext - b_ext;
      OpMult:  wr_result = a_ext * b_ext;
      OpDiv: begin
        if (b_zero) wr_err = 1'b1;
        else        wr_result = a_ext / div_b;
      end
      OpMod: begin
        if (b_zero) wr_err = 1'b1;
        else        wr_result = a_ext % div_b;
      end
      default:     wr_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      op_mem[write_pointer]  <= opcode;
      a_mem[write_pointer]   <= operand_a;
      b_mem[write_pointer]   <= operand_b;
      res_mem[write_pointer] <= wr_result;
      err_mem[write_pointer] <= wr_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (wr_en) begin
      valid_q[write_pointer] <= 1'b1;
      if (!valid_q[write_pointer]) count_q <= count_q + (AW + 1)'(1);
    end
  end

  // Reads sample pre-edge state, giving read-before-write and pre-clear semantics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q       <= 1'b0;
      rd_opcode_q      <= '0;
      rd_op_a_q        <= '0;
      rd_op_b_q        <= '0;
      rd_result_q      <= '0;
      rd_entry_valid_q <= 1'b0;
      rd_err_q         <= 1'b0;
    end else begin
      rd_valid_q <= read_en;
      if (read_en) begin
        if (rd_hit) begin
          rd_opcode_q      <= op_mem[read_pointer];
          rd_op_a_q        <= a_mem[read_pointer];
          rd_op_b_q        <= b_mem[read_pointer];
          rd_result_q      <= res_mem[read_pointer];
          rd_entry_valid_q <= 1'b1;
          rd_err_q         <= err_mem[read_pointer];
        end else begin
          rd_opcode_q      <= '0;
          rd_op_a_q        <= '0;
          rd_op_b_q        <= '0;
          rd_result_q      <= '0;
          rd_entry_valid_q <= 1'b0;
          rd_err_q         <= 1'b0;
        end
      end
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_opcode      = rd_opcode_q;
  assign rd_op_a        = rd_op_a_q;
  assign rd_op_b        = rd_op_b_q;
  assign rd_result      = rd_result_q;
  assign rd_entry_valid = rd_entry_valid_q;
  assign rd_err         = rd_err_q;
  assign entry_count    = count_q;

endmodule

// File: tb/tb_instr_register_exec.sv
// Scoreboard bench for instr_register_exec: a reference model predicts each read when it is
// issued; the prediction is popped and compared when rd_valid appears.
module tb_instr_register_exec;

  localparam int DEPTH = 32;
  localparam int OPW   = 32;
  localparam int AW    = 5;
  localparam int RW    = 64;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           load_en = 1'b0;
  logic [AW-1:0]  write_pointer = '0;
  logic [3:0]     opcode = '0;
  logic [OPW-1:0] operand_a = '0;
  logic [OPW-1:0] operand_b = '0;
  logic           clear = 1'b0;
  logic           read_en = 1'b0;
  logic [AW-1:0]  read_pointer = '0;
  logic           rd_valid;
  logic [3:0]     rd_opcode;
  logic [OPW-1:0] rd_op_a;
  logic [OPW-1:0] rd_op_b;
  logic [RW-1:0]  rd_result;
  logic           rd_entry_valid;
  logic           rd_err;
  logic [AW:0]    entry_count;

  instr_register_exec #(.DEPTH(DEPTH), .OP_WIDTH(OPW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_en        (load_en),
    .write_pointer  (write_pointer),
    .opcode         (opcode),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .clear          (clear),
    .read_en        (read_en),
    .read_pointer   (read_pointer),
    .rd_valid       (rd_valid),
    .rd_opcode      (rd_opcode),
    .rd_op_a        (rd_op_a),
    .rd_op_b        (rd_op_b),
    .rd_result      (rd_result),
    .rd_entry_valid (rd_entry_valid),
    .rd_err         (rd_err),
    .entry_count    (entry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic        m_valid [DEPTH];
  logic [3:0]  m_op    [DEPTH];
  logic [31:0] m_a     [DEPTH];
  logic [31:0] m_b     [DEPTH];
  logic [63:0] m_res   [DEPTH];
  logic        m_err   [DEPTH];
  int          m_count = 0;
  int          n_err = 0;
  int          n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [63:0] res,
                                   output logic err);
    int     ia;
    int     ib;
    longint x;
    longint y;
    ia = a;
    ib = b;
    x = ia;
    y = ib;
    res = '0;
    err = 1'b0;
    case (op)
      4'd0: res = '0;
      4'd1: res = 64'(x);
      4'd2: res = 64'(y);
      4'd3: res = 64'(x + y);
      4'd4: res = 64'(x - y);
      4'd5: res = 64'(x * y);
      4'd6: if (y == 0) err = 1'b1; else res = 64'(x / y);
      4'd7: if (y == 0) err = 1'b1; else res = 64'(x % y);
      default: err = 1'b1;
    endcase
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.ev = 1'b0; e.op = '0; e.a = '0; e.b = '0; e.res = '0; e.err = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic tick();
    logic pend;
    exp_t e;
    pend = read_en;
    @(posedge clk);
    #1;
    check("rd_valid", 64'(rd_valid), 64'(pend));
    check("entry_count", 64'(entry_count), 64'(m_count));
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(rd_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("rd_entry_valid", 64'(rd_entry_valid), 64'(e.ev));
        check("rd_opcode", 64'(rd_opcode), 64'(e.op));
        check("rd_op_a", 64'(rd_op_a), 64'(e.a));
        check("rd_op_b", 64'(rd_op_b), 64'(e.b));
        check("rd_result", rd_result, e.res);
        check("rd_err", 64'(rd_err), 64'(e.err));
        last = e;
      end
    end else begin
      check("hold_result", rd_result, last.res);
      check("hold_op_a", 64'(rd_op_a), 64'(last.a));
      check("hold_entry_valid", 64'(rd_entry_valid), 64'(last.ev));
    end
  endtask

  task automatic step(input logic ld, input int wp, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rd, input int rp, input logic clr);
    exp_t        e;
    logic [63:0] r;
    logic        er;
    if (rd) begin
      e = zero_exp();
      if (m_valid[rp]) begin
        e.ev = 1'b1; e.op = m_op[rp]; e.a = m_a[rp]; e.b = m_b[rp];
        e.res = m_res[rp]; e.err = m_err[rp];
      end
      sb.push_back(e);
    end
    if (clr) begin
      model_reset();
    end else if (ld) begin
      ref_calc(op, a, b, r, er);
      if (!m_valid[wp]) m_count++;
      m_valid[wp] = 1'b1;
      m_op[wp] = op; m_a[wp] = a; m_b[wp] = b; m_res[wp] = r; m_err[wp] = er;
    end
    load_en       = ld;
    write_pointer = AW'(wp);
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
    read_en       = rd;
    read_pointer  = AW'(rp);
    clear         = clr;
    tick();
  endtask

  task automatic wr(input int wp, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    step(1'b1, wp, op, a, b, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int rp);
    step(1'b0, 0, 4'd0, 32'd0, 32'd0, 1'b1, rp, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 4'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    last = zero_exp();
    model_reset();
    #1;
    check("reset_rd_valid", 64'(rd_valid), 64'(0));
    check("reset_count", 64'(entry_count), 64'(0));
    check("reset_result", rd_result, 64'(0));
    check("reset_entry_valid", 64'(rd_entry_valid), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ADD with negative operand
    wr(0, 4'd3, -32'sd15, 32'sd7);
    rd(0);
    check("add_result", rd_result, 64'hFFFF_FFFF_FFFF_FFF8);
    check("add_err", 64'(rd_err), 64'(0));
    check("add_entry_valid", 64'(rd_entry_valid), 64'(1));
    check("add_count", 64'(entry_count), 64'(1));
    idle();

    // MULT full width, signed DIV and MOD
    wr(3, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wr(4, 4'd6, -32'sd7, 32'sd2);
    wr(5, 4'd7, -32'sd7, 32'sd2);
    rd(3);
    check("mult_result", rd_result, 64'h3FFF_FFFF_0000_0001);
    rd(4);
    check("div_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFD);
    rd(5);
    check("mod_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFF);

    // Divide by zero, reserved opcode, never-written entry
    wr(7, 4'd6, 32'sd5, 32'sd0);
    wr(8, 4'd12, 32'sd3, 32'sd4);
    rd(7);
    check("div0_result", rd_result, 64'(0));
    check("div0_err", 64'(rd_err), 64'(1));
    rd(8);
    check("resv_err", 64'(rd_err), 64'(1));
    rd(9);
    check("unwritten_entry_valid", 64'(rd_entry_valid), 64'(0));
    check("unwritten_result", rd_result, 64'(0));
    idle();

    // Overwrite does not bump the count; same-edge read returns the old contents
    step(1'b0, 0, 4'd0, 32'd0, 32'd0, 1'b0, 0, 1'b1);
    wr(2, 4'd3, 32'sd1, 32'sd2);
    wr(2, 4'd4, 32'sd10, 32'sd4);
    wr(31, 4'd1, 32'sd42, 32'sd0);
    check("overwrite_count", 64'(entry_count), 64'(2));
    step(1'b1, 2, 4'd2, 32'd0, 32'd99, 1'b1, 2, 1'b0);
    check("rbw_result", rd_result, 64'(6));
    rd(2);
    check("after_write_result", rd_result, 64'(99));

    // Clear beats a simultaneous write; a read in the same cycle sees pre-clear data
    step(1'b1, 6, 4'd3, 32'd1, 32'd1, 1'b1, 2, 1'b1);
    check("clear_count", 64'(entry_count), 64'(0));
    check("preclear_entry_valid", 64'(rd_entry_valid), 64'(1));
    rd(6);
    check("cleared_entry_valid", 64'(rd_entry_valid), 64'(0));

    // Reset during a read result cycle
    wr(0, 4'd1, 32'sd11, 32'sd0);
    rd(0);
    read_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_rd_valid", 64'(rd_valid), 64'(0));
    check("midrst_count", 64'(entry_count), 64'(0));
    check("midrst_result", rd_result, 64'(0));
    model_reset();
    sb.delete();
    last = zero_exp();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wr(1, 4'd3, 32'sd20, 32'sd22);
    idle();
    rd(1);
    check("post_reset_result", rd_result, 64'(42));

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40)) - 32'd20;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 16)) - 32'd8;
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           4'($urandom_range(0, 15)), a, b, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 15) == 0));
    end
    idle();
    idle();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
